// File: rtl/two_level_bpred.sv
// Local-history two-level branch predictor.
// A per-branch history table (BHT) selects a row of saturating counters (PHT).
// Lookups are registered with one cycle of latency. Retire trains both tables
// using the indices that travelled down the pipeline with the prediction.
// After reset or flush, the PHT is cleared one entry per cycle while busy is high.
module two_level_bpred #(
  parameter int PC_W      = 32,
  parameter int BHT_IDX_W = 4,
  parameter int HIST_W    = 4,
  parameter int PC_BITS   = 3,
  parameter int PC_LSB    = 2,
  parameter int CTR_W     = 2,
  localparam int PHT_W    = PC_BITS + HIST_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  output logic                 busy,
  input  logic                 lk_valid,
  input  logic [PC_W-1:0]      lk_pc,
  output logic                 pred_valid,
  output logic                 pred_taken,
  output logic [PHT_W-1:0]     pred_pht_index,
  output logic [BHT_IDX_W-1:0] pred_bht_index,
  input  logic                 upd_valid,
  input  logic [PHT_W-1:0]     upd_pht_index,
  input  logic [BHT_IDX_W-1:0] upd_bht_index,
  input  logic                 upd_taken
);

  localparam int PHT_DEPTH = 1 << PHT_W;
  localparam int BHT_DEPTH = 1 << BHT_IDX_W;
  localparam int N_CHUNKS  = PC_W / BHT_IDX_W;
  // Weakly not-taken: MSB clear, all lower bits set.
  localparam logic [CTR_W-1:0] CLR_VAL = {1'b0, {(CTR_W-1){1'b1}}};

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t               state;
  logic [PHT_W-1:0]     clr_ptr;
  logic                 busy_r;

  logic [CTR_W-1:0]     pht [PHT_DEPTH];
  logic [HIST_W-1:0]    bht [BHT_DEPTH];

  logic                 run_p0;
  logic                 lk_fire_p0;
  logic                 upd_fire_p0;
  logic [BHT_IDX_W-1:0] lk_bht_idx_p0;
  logic [PHT_W-1:0]     lk_pht_idx_p0;

  logic                 vld_p1;
  logic                 pred_taken_p1;
  logic [PHT_W-1:0]     pred_pht_idx_p1;
  logic [BHT_IDX_W-1:0] pred_bht_idx_p1;

  // XOR-fold the whole PC into a BHT index so every PC bit contributes.
  function automatic logic [BHT_IDX_W-1:0] fold_pc(input logic [PC_W-1:0] pc);
    logic [BHT_IDX_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < N_CHUNKS; i++) begin
      acc ^= pc[i*BHT_IDX_W +: BHT_IDX_W];
    end
    return acc;
  endfunction

  // Saturating up/down step of one PHT counter.
  function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] c,
                                                input logic             taken);
    if (taken) begin
      return (&c) ? c : c + CTR_W'(1);
    end else begin
      return (c == '0) ? c : c - CTR_W'(1);
    end
  endfunction

  // ---- stage p0: table read and index formation (combinational) ----
  assign run_p0        = (state == ST_RUN);
  assign lk_fire_p0    = run_p0 & lk_valid & ~reset;
  assign upd_fire_p0   = run_p0 & upd_valid & ~reset & ~flush;
  assign lk_bht_idx_p0 = fold_pc(lk_pc);
  assign lk_pht_idx_p0 = {lk_pc[PC_LSB+PC_BITS-1:PC_LSB], bht[lk_bht_idx_p0]};

  // Clear sequencer: walks clr_ptr over the PHT, restarting on reset or flush.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
      busy_r  <= 1'b1;
    end else if (state == ST_CLEAR) begin
      clr_ptr <= clr_ptr + 1'b1;
      if (clr_ptr == {PHT_W{1'b1}}) begin
        state  <= ST_RUN;
        busy_r <= 1'b0;
      end
    end
  end

  // PHT write port: clear writes while sequencing, otherwise retire training.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      pht[clr_ptr] <= CLR_VAL;
    end else if (upd_fire_p0) begin
      pht[upd_pht_index] <= ctr_next(pht[upd_pht_index], upd_taken);
    end
  end

  // BHT: wiped in one edge on reset/flush, otherwise shifts in resolved outcomes.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= '0;
      end
    end else if (upd_fire_p0) begin
      bht[upd_bht_index] <= {bht[upd_bht_index][HIST_W-2:0], upd_taken};
    end
  end

  // ---- stage p1: registered prediction, indices held when idle ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1          <= 1'b0;
      pred_taken_p1   <= 1'b0;
      pred_pht_idx_p1 <= '0;
      pred_bht_idx_p1 <= '0;
    end else if (lk_fire_p0) begin
      vld_p1          <= 1'b1;
      pred_taken_p1   <= pht[lk_pht_idx_p0][CTR_W-1];
      pred_pht_idx_p1 <= lk_pht_idx_p0;
      pred_bht_idx_p1 <= lk_bht_idx_p0;
    end else begin
      vld_p1          <= 1'b0;
    end
  end

  assign busy           = busy_r;
  assign pred_valid     = vld_p1;
  assign pred_taken     = pred_taken_p1;
  assign pred_pht_index = pred_pht_idx_p1;
  assign pred_bht_index = pred_bht_idx_p1;

endmodule

// File: tb/tb_two_level_bpred.sv
// Bench for two_level_bpred: directed scenarios followed by random traffic,
// checked against a table-level reference model through a scoreboard queue.
module tb_two_level_bpred;

  localparam int PHT_W     = 7;
  localparam int PHT_DEPTH = 128;
  localparam int BHT_DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        busy;
  logic        lk_valid = 1'b0;
  logic [31:0] lk_pc = '0;
  logic        pred_valid;
  logic        pred_taken;
  logic [6:0]  pred_pht_index;
  logic [3:0]  pred_bht_index;
  logic        upd_valid = 1'b0;
  logic [6:0]  upd_pht_index = '0;
  logic [3:0]  upd_bht_index = '0;
  logic        upd_taken = 1'b0;

  two_level_bpred dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .busy           (busy),
    .lk_valid       (lk_valid),
    .lk_pc          (lk_pc),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .pred_pht_index (pred_pht_index),
    .pred_bht_index (pred_bht_index),
    .upd_valid      (upd_valid),
    .upd_pht_index  (upd_pht_index),
    .upd_bht_index  (upd_bht_index),
    .upd_taken      (upd_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   due;
    logic taken;
    int   pht;
    int   bht;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;
  bit   exp_busy = 1'b1;

  // Reference model state: counter values, histories, and remaining clear cycles.
  int m_ctr  [PHT_DEPTH];
  int m_hist [BHT_DEPTH];
  int m_clear_left = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int fold(input logic [31:0] pc);
    int r = 0;
    for (int i = 0; i < 8; i++) r = r ^ int'((pc >> (4 * i)) & 32'hF);
    return r;
  endfunction

  task automatic model_wipe();
    m_clear_left = PHT_DEPTH;
    for (int i = 0; i < PHT_DEPTH; i++) m_ctr[i] = 1;
    for (int i = 0; i < BHT_DEPTH; i++) m_hist[i] = 0;
  endtask

  // Apply one clock edge's worth of inputs to the model (called before the edge).
  task automatic model_step(input bit rst, input bit fl, input bit lkv,
                            input logic [31:0] pc, input bit upv, input int up_p,
                            input int up_b, input bit up_t);
    bit   run;
    exp_t e;
    if (rst) begin
      model_wipe();
    end else begin
      run = (m_clear_left == 0);
      if (run && lkv) begin
        e.due   = cyc + 1;
        e.bht   = fold(pc);
        e.pht   = int'((pc >> 2) & 32'h7) * 16 + m_hist[e.bht];
        e.taken = (m_ctr[e.pht] >= 2);
        q.push_back(e);
      end
      if (fl) begin
        model_wipe();
      end else if (run && upv) begin
        if (up_t) m_ctr[up_p] = (m_ctr[up_p] == 3) ? 3 : m_ctr[up_p] + 1;
        else      m_ctr[up_p] = (m_ctr[up_p] == 0) ? 0 : m_ctr[up_p] - 1;
        m_hist[up_b] = ((m_hist[up_b] * 2) + int'(up_t)) % 16;
      end else if (!run) begin
        m_clear_left--;
      end
    end
    exp_busy = (m_clear_left > 0);
  endtask

  task automatic step(input bit rst, input bit fl, input bit lkv, input logic [31:0] pc,
                      input bit upv, input int up_p, input int up_b, input bit up_t);
    @(negedge clk);
    reset         = rst;
    flush         = fl;
    lk_valid      = lkv;
    lk_pc         = pc;
    upd_valid     = upv;
    upd_pht_index = up_p[6:0];
    upd_bht_index = up_b[3:0];
    upd_taken     = up_t;
    model_step(rst, fl, lkv, pc, upv, up_p, up_b, up_t);
    if (rst) mon_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 0, 0, 0, 0);
  endtask

  task automatic lookup(input logic [31:0] pc);
    step(0, 0, 1, pc, 0, 0, 0, 0);
  endtask

  task automatic train(input int p, input int b, input bit t);
    step(0, 0, 0, 32'h0, 1, p, b, t);
  endtask

  // Monitor: checks busy every cycle and matches predictions against the queue.
  logic       last_taken = 1'b0;
  int         last_pht   = 0;
  int         last_bht   = 0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (mon_en) begin
      chk("busy", int'(busy), int'(exp_busy));
      if (pred_valid) begin
        if (q.size() == 0 || q[0].due != cyc) begin
          chk("spurious_pred_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("pred_taken", int'(pred_taken), int'(e.taken));
          chk("pred_pht_index", int'(pred_pht_index), e.pht);
          chk("pred_bht_index", int'(pred_bht_index), e.bht);
          last_taken = e.taken;
          last_pht   = e.pht;
          last_bht   = e.bht;
        end
      end else begin
        if (q.size() != 0 && q[0].due == cyc) begin
          chk("missing_pred_valid", 0, 1);
          void'(q.pop_front());
        end
        chk("hold_pred_taken", int'(pred_taken), int'(last_taken));
        chk("hold_pht_index", int'(pred_pht_index), last_pht);
        chk("hold_bht_index", int'(pred_bht_index), last_bht);
      end
    end
  end

  initial begin
    // Reset, then the full clear with lookups and updates that must be ignored.
    step(1, 0, 0, 32'h0, 0, 0, 0, 0);
    for (int i = 0; i < PHT_DEPTH; i++)
      step(0, 0, 1, $urandom, 1, int'($urandom_range(0, 127)), int'($urandom_range(0, 15)), 1);

    // First lookup after clear.
    lookup(32'h0000_0004);
    idle(1);

    // Counter saturation on PHT 0x10, trained through an unrelated BHT entry.
    train(16, 15, 1);
    train(16, 15, 1);
    lookup(32'h0000_0004);
    for (int i = 0; i < 3; i++) train(16, 15, 1);
    lookup(32'h0000_0004);
    for (int i = 0; i < 3; i++) train(16, 15, 0);
    lookup(32'h0000_0004);
    train(16, 15, 0);
    lookup(32'h0000_0004);

    // History shift on BHT 4: T,T,N,T,T.
    train(127, 4, 1);
    train(127, 4, 1);
    train(127, 4, 0);
    train(127, 4, 1);
    train(127, 4, 1);
    lookup(32'h0000_0004);

    // Same-cycle lookup and update of PHT 0x10 (pc 0x104 folds to BHT 5, history 0).
    train(16, 15, 1);
    step(0, 0, 1, 32'h0000_0104, 1, 16, 15, 1);
    lookup(32'h0000_0104);
    idle(1);

    // Training, flush, second flush at clear pointer 50, updates while busy.
    for (int i = 0; i < 20; i++)
      step(0, 0, 1, $urandom & 32'hFF, 1, int'($urandom_range(0, 127)),
           int'($urandom_range(0, 15)), 1'($urandom));
    step(0, 1, 0, 32'h0, 0, 0, 0, 0);
    for (int i = 0; i < 50; i++)
      step(0, 0, 1, $urandom, 1, int'($urandom_range(0, 127)), int'($urandom_range(0, 15)), 1);
    step(0, 1, 0, 32'h0, 1, 16, 4, 1);
    for (int i = 0; i < PHT_DEPTH; i++)
      step(0, 0, 1, $urandom, 1, int'($urandom_range(0, 127)), int'($urandom_range(0, 15)), 1);
    for (int i = 0; i < 200; i++) lookup($urandom);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 2500; i++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 1) == 1) ? ($urandom & 32'h0000_01FC) : $urandom;
      step(0, ($urandom_range(0, 599) == 0), ($urandom_range(0, 3) != 0), pc,
           ($urandom_range(0, 1) == 1), int'($urandom_range(0, 127)),
           int'($urandom_range(0, 15)), 1'($urandom));
    end

    idle(3);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
